// File: rtl/surf_l2_trigger_receiver_pkg.sv
// Shared constants for the SURF L2 trigger receiver: line map and
// default timing/width parameters.
package surf_l2_trigger_receiver_pkg;

    localparam int N_LINES      = 4;
    localparam int N_PHI        = 2;

    localparam int PHI0_LINE    = 0;
    localparam int PHI1_LINE    = 2;
    localparam int UNUSED0_LINE = 1;
    localparam int UNUSED1_LINE = 3;

    localparam int DEF_WINDOW   = 3;
    localparam int DEF_HOLDOFF  = 8;
    localparam int DEF_SCALER_W = 16;

endpackage

// File: rtl/surf_l2_trigger_receiver_l2_edge_sync.sv
// One trigger line: 2-flop synchronizer, history flop and a
// registered single-cycle rising-edge pulse.
module surf_l2_trigger_receiver_l2_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_sync,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_line;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_rise;

endmodule

// File: rtl/surf_l2_trigger_receiver.sv
// SURF per-phi L2 receiver: edge extraction, windowed adjacent-phi
// L3 coincidence with holdoff, saturating L2 scalers, link error flag.
module surf_l2_trigger_receiver
    import surf_l2_trigger_receiver_pkg::*;
#(
    parameter int WINDOW   = DEF_WINDOW,
    parameter int HOLDOFF  = DEF_HOLDOFF,
    parameter int SCALER_W = DEF_SCALER_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            trig_i,
    input  logic [1:0]            mask_i,
    input  logic                  or_mode_i,
    input  logic                  scaler_latch_i,
    output logic                  l3_o,
    output logic [1:0]            l3_phi_o,
    output logic                  busy_o,
    output logic [2*SCALER_W-1:0] l2_scaler_o,
    output logic                  link_err_o
);

    localparam logic [3:0]          LP_WIN  = 4'(WINDOW);
    localparam logic [7:0]          LP_HOLD = 8'(HOLDOFF);
    localparam logic [SCALER_W-1:0] LP_SAT  = {SCALER_W{1'b1}};
    localparam logic [SCALER_W-1:0] LP_ONE  = SCALER_W'(1);

    logic [N_LINES-1:0] w_sync;
    logic [N_LINES-1:0] w_rise;

    for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
        surf_l2_trigger_receiver_l2_edge_sync u_sync (
            .i_clk  (clk_i),
            .i_rst  (rst_i),
            .i_line (trig_i[gi]),
            .o_sync (w_sync[gi]),
            .o_rise (w_rise[gi])
        );
    end

    logic [1:0] w_rise_phi;
    logic [1:0] w_urise;
    logic [1:0] w_open;
    logic [1:0] w_phi;
    logic       w_hold;
    logic       w_and;
    logic       w_fire;
    logic       w_unused;

    logic [1:0][3:0]          r_win;
    logic [7:0]               r_hold;
    logic [1:0][SCALER_W-1:0] r_cnt;
    logic                     r_l3;
    logic [1:0]               r_l3_phi;
    logic [2*SCALER_W-1:0]    r_scaler;
    logic                     r_link_err;

    assign w_rise_phi = {w_rise[PHI1_LINE], w_rise[PHI0_LINE]};
    assign w_urise    = w_rise_phi & ~mask_i;
    assign w_open[0]  = (r_win[0] != 4'd0) | w_rise_phi[0];
    assign w_open[1]  = (r_win[1] != 4'd0) | w_rise_phi[1];
    assign w_hold     = (r_hold != 8'd0);

    // A fresh unmasked edge on one phi pairs with the other phi's open window
    assign w_and  = (w_urise[0] & w_open[1] & ~mask_i[1])
                  | (w_urise[1] & w_open[0] & ~mask_i[0]);
    assign w_fire = ~w_hold & (or_mode_i ? (|w_urise) : w_and);
    assign w_phi  = or_mode_i ? w_urise : 2'b11;

    assign w_unused = ^{w_rise[UNUSED0_LINE], w_rise[UNUSED1_LINE],
                        w_sync[PHI0_LINE], w_sync[PHI1_LINE]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_win      <= '0;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_l3       <= 1'b0;
            r_l3_phi   <= 2'b00;
            r_scaler   <= '0;
            r_link_err <= 1'b0;
        end else begin
            r_l3     <= w_fire;
            r_l3_phi <= w_fire ? w_phi : 2'b00;

            if (w_fire) begin
                r_hold <= LP_HOLD;
            end else if (w_hold) begin
                r_hold <= r_hold - 8'd1;
            end

            for (int p = 0; p < N_PHI; p++) begin
                if (w_fire) begin
                    r_win[p] <= 4'd0;
                end else if (w_urise[p] && !w_hold) begin
                    r_win[p] <= LP_WIN;
                end else if (r_win[p] != 4'd0) begin
                    r_win[p] <= r_win[p] - 4'd1;
                end

                // An edge coincident with the latch opens the new period
                if (scaler_latch_i) begin
                    r_cnt[p] <= SCALER_W'(w_rise_phi[p]);
                end else if (w_rise_phi[p] && r_cnt[p] != LP_SAT) begin
                    r_cnt[p] <= r_cnt[p] + LP_ONE;
                end
            end

            if (scaler_latch_i) begin
                r_scaler <= r_cnt;
            end

            if (w_sync[UNUSED0_LINE] | w_sync[UNUSED1_LINE]) begin
                r_link_err <= 1'b1;
            end
        end
    end

    assign l3_o        = r_l3;
    assign l3_phi_o    = r_l3_phi;
    assign busy_o      = w_hold;
    assign l2_scaler_o = r_scaler;
    assign link_err_o  = r_link_err;

endmodule

// File: tb/tb_surf_l2_trigger_receiver.sv
// Scoreboard bench for surf_l2_trigger_receiver: expected L3 events are
// queued at stimulus time and matched against monitored l3_o pulses.
module tb_surf_l2_trigger_receiver;

    localparam int WIN = 3;
    localparam int HO  = 8;
    localparam int SW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      trig = 4'd0;
    logic [1:0]      mask = 2'd0;
    logic            orm = 1'b0;
    logic            latch = 1'b0;
    logic            l3;
    logic [1:0]      l3phi;
    logic            busy;
    logic [2*SW-1:0] scal;
    logic            lerr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_cnt = 0;

    int         exp_cyc[$];
    logic [1:0] exp_phi[$];
    int         obs_cyc[$];
    logic [1:0] obs_phi[$];

    surf_l2_trigger_receiver #(
        .WINDOW   (WIN),
        .HOLDOFF  (HO),
        .SCALER_W (SW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .trig_i         (trig),
        .mask_i         (mask),
        .or_mode_i      (orm),
        .scaler_latch_i (latch),
        .l3_o           (l3),
        .l3_phi_o       (l3phi),
        .busy_o         (busy),
        .l2_scaler_o    (scal),
        .link_err_o     (lerr)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (l3 === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_phi.push_back(l3phi);
        end
        if (busy === 1'b1) busy_cnt++;
    end

    // Drive phi0/phi1 pulses; base is the edge that samples k = 0.
    task automatic sched(input int a0, input int l0, input int a1,
                         input int l1, input int n, output int base);
        base = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) base = cyc + 1;
            trig[0] = (k >= a0) && (k < a0 + l0);
            trig[2] = (k >= a1) && (k < a1 + l1);
        end
        @(negedge clk);
        trig[0] = 1'b0;
        trig[2] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch();
        @(negedge clk);
        latch = 1'b1;
        @(negedge clk);
        latch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        n_chk++;
        if (l3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_l3: got %b expected 0", l3);
        end
        n_chk++;
        if (l3phi !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_phi: got %b expected 00", l3phi);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_chk++;
        if (scal !== '0) begin
            n_fail++;
            $display("FAIL reset_scaler: got %h expected 0", scal);
        end
        n_chk++;
        if (lerr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_linkerr: got %b expected 0", lerr);
        end
    endtask

    task automatic test_and_coinc();
        int b;
        busy_cnt = 0;
        sched(0, 3, 2, 3, 6, b);
        exp_cyc.push_back(b + 2 + 3);
        exp_phi.push_back(2'b11);
        idle(20);
        n_chk++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            n_fail++;
            $display("FAIL and_count: got %0d expected %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
            int oc = obs_cyc.pop_front();
            int ec = exp_cyc.pop_front();
            logic [1:0] op = obs_phi.pop_front();
            logic [1:0] ep = exp_phi.pop_front();
            n_chk++;
            if (oc !== ec || op !== ep) begin
                n_fail++;
                $display("FAIL and_l3: got cyc %0d phi %b expected cyc %0d phi %b",
                         oc, op, ec, ep);
            end
        end
        obs_cyc.delete(); obs_phi.delete();
        exp_cyc.delete(); exp_phi.delete();
        n_chk++;
        if (busy_cnt != HO) begin
            n_fail++;
            $display("FAIL and_busy: got %0d expected %0d", busy_cnt, HO);
        end
        do_latch();
        n_chk++;
        if (scal !== {8'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL and_scaler: got %h expected 0101", scal);
        end
    endtask

    task automatic test_window();
        int b;
        int fires = 0;
        int a0s[4] = '{0, 0, 0, 3};
        int a1s[4] = '{3, 4, 5, 0};
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            int d = (a1s[i] > a0s[i]) ? a1s[i] - a0s[i] : a0s[i] - a1s[i];
            int last = (a1s[i] > a0s[i]) ? a1s[i] : a0s[i];
            sched(a0s[i], 3, a1s[i], 3, last + 4, b);
            if (d <= WIN) begin
                exp_cyc.push_back(b + last + 3);
                exp_phi.push_back(2'b11);
                fires++;
            end
            idle(20);
        end
        n_chk++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            n_fail++;
            $display("FAIL win_count: got %0d expected %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
            int oc = obs_cyc.pop_front();
            int ec = exp_cyc.pop_front();
            logic [1:0] op = obs_phi.pop_front();
            logic [1:0] ep = exp_phi.pop_front();
            n_chk++;
            if (oc !== ec || op !== ep) begin
                n_fail++;
                $display("FAIL win_l3: got cyc %0d phi %b expected cyc %0d phi %b",
                         oc, op, ec, ep);
            end
        end
        obs_cyc.delete(); obs_phi.delete();
        exp_cyc.delete(); exp_phi.delete();
        n_chk++;
        if (busy_cnt != HO * fires) begin
            n_fail++;
            $display("FAIL win_busy: got %0d expected %0d", busy_cnt, HO * fires);
        end
        do_latch();
        n_chk++;
        if (scal !== {8'd4, 8'd4}) begin
            n_fail++;
            $display("FAIL win_scaler: got %h expected 0404", scal);
        end
    endtask

    task automatic test_back_to_back();
        int b1;
        int b2;
        int gaps[3] = '{4, 8, 9};
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            sched(0, 2, 0, 2, gaps[i] - 1, b1);
            sched(0, 2, 0, 2, 3, b2);
            exp_cyc.push_back(b1 + 3);
            exp_phi.push_back(2'b11);
            if (b2 - b1 > HO) begin
                exp_cyc.push_back(b2 + 3);
                exp_phi.push_back(2'b11);
            end
            idle(20);
        end
        n_chk++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
            int oc = obs_cyc.pop_front();
            int ec = exp_cyc.pop_front();
            logic [1:0] op = obs_phi.pop_front();
            logic [1:0] ep = exp_phi.pop_front();
            n_chk++;
            if (oc !== ec || op !== ep) begin
                n_fail++;
                $display("FAIL b2b_l3: got cyc %0d phi %b expected cyc %0d phi %b",
                         oc, op, ec, ep);
            end
        end
        obs_cyc.delete(); obs_phi.delete();
        exp_cyc.delete(); exp_phi.delete();
        n_chk++;
        if (busy_cnt != HO * 4) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d expected %0d", busy_cnt, HO * 4);
        end
        do_latch();
        n_chk++;
        if (scal !== {8'd6, 8'd6}) begin
            n_fail++;
            $display("FAIL b2b_scaler: got %h expected 0606", scal);
        end
    endtask

    task automatic test_or_mask();
        int b;
        orm = 1'b1;
        mask = 2'b01;
        sched(0, 3, 20, 3, 24, b);
        exp_cyc.push_back(b + 20 + 3);
        exp_phi.push_back(2'b10);
        idle(20);
        mask = 2'b11;
        sched(0, 3, 0, 3, 4, b);
        idle(20);
        orm = 1'b0;
        sched(0, 3, 0, 3, 4, b);
        idle(20);
        mask = 2'b00;
        n_chk++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            n_fail++;
            $display("FAIL or_count: got %0d expected %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
            int oc = obs_cyc.pop_front();
            int ec = exp_cyc.pop_front();
            logic [1:0] op = obs_phi.pop_front();
            logic [1:0] ep = exp_phi.pop_front();
            n_chk++;
            if (oc !== ec || op !== ep) begin
                n_fail++;
                $display("FAIL or_l3: got cyc %0d phi %b expected cyc %0d phi %b",
                         oc, op, ec, ep);
            end
        end
        obs_cyc.delete(); obs_phi.delete();
        exp_cyc.delete(); exp_phi.delete();
        do_latch();
        n_chk++;
        if (scal !== {8'd3, 8'd3}) begin
            n_fail++;
            $display("FAIL or_scaler: got %h expected 0303", scal);
        end
    endtask

    task automatic test_saturation();
        int b;
        for (int i = 0; i < 300; i++) sched(0, 1, 99, 0, 1, b);
        idle(10);
        do_latch();
        n_chk++;
        if (scal !== {8'd0, 8'd255}) begin
            n_fail++;
            $display("FAIL sat_scaler: got %h expected 00ff", scal);
        end
        n_chk++;
        if (obs_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL sat_nol3: got %0d expected 0", obs_cyc.size());
        end
        @(negedge clk); trig[0] = 1'b1;
        @(negedge clk); trig[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); latch = 1'b1;
        @(negedge clk); latch = 1'b0;
        n_chk++;
        if (scal !== '0) begin
            n_fail++;
            $display("FAIL sat_empty_period: got %h expected 0000", scal);
        end
        idle(5);
        do_latch();
        n_chk++;
        if (scal !== {8'd0, 8'd1}) begin
            n_fail++;
            $display("FAIL sat_coincident: got %h expected 0001", scal);
        end
    endtask

    task automatic test_link_reset();
        int b;
        int b2;
        @(negedge clk); trig[3] = 1'b1;
        @(negedge clk); trig[3] = 1'b0;
        idle(5);
        n_chk++;
        if (lerr !== 1'b1) begin
            n_fail++;
            $display("FAIL link_set: got %b expected 1", lerr);
        end
        orm = 1'b1;
        sched(0, 3, 99, 0, 4, b);
        exp_cyc.push_back(b + 3);
        exp_phi.push_back(2'b01);
        idle(1);
        n_chk++;
        if (busy !== 1'b1 || lerr !== 1'b1) begin
            n_fail++;
            $display("FAIL link_busy: got busy %b err %b expected 1 1", busy, lerr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({l3, l3phi, busy, scal, lerr} !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: got l3 %b phi %b busy %b scal %h err %b expected all 0",
                     l3, l3phi, busy, scal, lerr);
        end
        sched(0, 3, 99, 0, 4, b2);
        exp_cyc.push_back(b2 + 3);
        exp_phi.push_back(2'b01);
        idle(20);
        orm = 1'b0;
        n_chk++;
        if (lerr !== 1'b0) begin
            n_fail++;
            $display("FAIL link_clear: got %b expected 0", lerr);
        end
        n_chk++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            n_fail++;
            $display("FAIL rst_count: got %0d expected %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
            int oc = obs_cyc.pop_front();
            int ec = exp_cyc.pop_front();
            logic [1:0] op = obs_phi.pop_front();
            logic [1:0] ep = exp_phi.pop_front();
            n_chk++;
            if (oc !== ec || op !== ep) begin
                n_fail++;
                $display("FAIL rst_l3: got cyc %0d phi %b expected cyc %0d phi %b",
                         oc, op, ec, ep);
            end
        end
        obs_cyc.delete(); obs_phi.delete();
        exp_cyc.delete(); exp_phi.delete();
    endtask

    initial begin
        test_reset();
        test_and_coinc();
        test_window();
        test_back_to_back();
        test_or_mask();
        test_saturation();
        test_link_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
